acc_core_mc: RTL and testbench

- Parametrised multicycle successor to the single-cycle accumulator core.
- Fetch/execute FSM drives an accumulator datapath with a register file.
- Instruction memory is read combinationally. Data memory uses a req/ack handshake, so memory latency may vary.
- Adds start/restart control, a latched done flag, and configurable data width, instruction width and register count.

---
 rtl/acc_core_pkg.sv | 61 ++++++
 rtl/acc_rf.sv | 44 ++++
 rtl/acc_core_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_acc_core_mc.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_core_pkg.sv
// ---------------------------------------------------------------------------
// acc_core_pkg
//   Shared definitions for the multicycle accumulator core:
//   - 4-bit opcode constants (kLDR .. kJMP); codes 13..15 are undefined and
//     execute as a NOP.
//   - Core FSM state encoding.
//   - ALU operation encoding and the opcode -> ALU-op decoder.
// ---------------------------------------------------------------------------
package acc_core_pkg;

    localparam logic [3:0] kLDR = 4'd0;
    localparam logic [3:0] kSTR = 4'd1;
    localparam logic [3:0] kLDI = 4'd2;
    localparam logic [3:0] kADD = 4'd3;
    localparam logic [3:0] kSUB = 4'd4;
    localparam logic [3:0] kAND = 4'd5;
    localparam logic [3:0] kXOR = 4'd6;
    localparam logic [3:0] kSHL = 4'd7;
    localparam logic [3:0] kLDM = 4'd8;
    localparam logic [3:0] kSTM = 4'd9;
    localparam logic [3:0] kBRZ = 4'd10;
    localparam logic [3:0] kBRN = 4'd11;
    localparam logic [3:0] kJMP = 4'd12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_e;

    // ALU_NONE means the instruction does not write the accumulator in EXEC
    // (stores, branches, jumps, memory ops and undefined opcodes).
    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_LDR  = 3'd1,
        ALU_LDI  = 3'd2,
        ALU_ADD  = 3'd3,
        ALU_SUB  = 3'd4,
        ALU_AND  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_SHL  = 3'd7
    } alu_op_e;

    function automatic alu_op_e decode_alu(input logic [3:0] opc);
        alu_op_e op;
        case (opc)
            kLDR:    op = ALU_LDR;
            kLDI:    op = ALU_LDI;
            kADD:    op = ALU_ADD;
            kSUB:    op = ALU_SUB;
            kAND:    op = ALU_AND;
            kXOR:    op = ALU_XOR;
            kSHL:    op = ALU_SHL;
            default: op = ALU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/acc_rf.sv
// ---------------------------------------------------------------------------
// acc_rf
//   NREG x DW register file for the accumulator core.
//   - Synchronous write, combinational read, synchronous clear on reset.
//   - A read of the index being written in the same cycle returns the old
//     contents (the write lands at the clock edge).
//
// Ports:
//   clk, reset   clock / synchronous active-high clear
//   we           write enable
//   waddr, wdata write index and data
//   raddr        read index
//   rdata        R[raddr] (zero for an index beyond NREG-1)
// ---------------------------------------------------------------------------
module acc_rf #(
    parameter int DW   = 8,
    parameter int NREG = 16,
    parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (int'(waddr) < NREG)) begin
            regs[waddr] <= wdata;
        end
    end

    // Non-power-of-two NREG leaves holes in the index space; they read zero.
    assign rdata = (int'(raddr) < NREG) ? regs[raddr] : '0;

endmodule

// File: rtl/acc_core_mc.sv
// ---------------------------------------------------------------------------
// acc_core_mc
//   Multicycle accumulator core. A FETCH/EXEC FSM runs programs from a
//   combinational instruction memory against an accumulator, a register
//   file and a req/ack data memory. Programs end with JMP 0, which parks
//   the core in HALT with done raised until the next start pulse.
//
//   Instruction format: inst[IW-1:IW-4] = opcode, inst[IW-5:0] = operand,
//   register index = operand[$clog2(NREG)-1:0].
//
// Ports:
//   clk, reset     clock / synchronous active-high reset
//   start          one-cycle pulse; starts (or restarts) at PC 0
//   done           high while halted after JMP 0
//   busy           high in FETCH, EXEC and MEM
//   imem_addr      current PC
//   imem_data      instruction at imem_addr (combinational)
//   dmem_req       data-memory request, held until dmem_ack
//   dmem_we        1 = write, 0 = read; valid with dmem_req
//   dmem_addr      R[idx] of the memory instruction
//   dmem_wdata     accumulator at the memory instruction
//   dmem_rdata     read data, valid with dmem_ack
//   dmem_ack       completes the pending request this cycle
// ---------------------------------------------------------------------------
module acc_core_mc
    import acc_core_pkg::*;
#(
    parameter int DW   = 8,
    parameter int IW   = 9,
    parameter int NREG = 16,
    parameter int PCW  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           done,
    output logic           busy,
    output logic [PCW-1:0] imem_addr,
    input  logic [IW-1:0]  imem_data,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic [DW-1:0]  dmem_rdata,
    input  logic           dmem_ack
);

    localparam int OW  = IW - 4;
    localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;

    state_e        state;
    logic [PCW-1:0] pc;
    logic [DW-1:0]  acc;
    logic [IW-1:0]  ir;
    logic           z;
    logic           neg;

    logic [3:0]     opcode;
    logic [OW-1:0]  operand;
    logic [RIW-1:0] idx;
    logic [DW-1:0]  rf_rdata;
    logic           rf_we;

    alu_op_e        alu_op;
    logic [DW-1:0]  acc_next;
    logic           acc_wr;

    assign opcode    = ir[IW-1:IW-4];
    assign operand   = ir[OW-1:0];
    assign idx       = operand[RIW-1:0];
    assign imem_addr = pc;

    // Operand zero-extended to the datapath width (truncated if wider).
    function automatic logic [DW-1:0] imm_data(input logic [OW-1:0] op);
        logic [DW+OW-1:0] wide;
        wide = {{DW{1'b0}}, op};
        return wide[DW-1:0];
    endfunction

    // Operand zero-extended to a PC value, used as the JMP target.
    function automatic logic [PCW-1:0] jump_target(input logic [OW-1:0] op);
        logic [PCW+OW-1:0] wide;
        wide = {{PCW{1'b0}}, op};
        return wide[PCW-1:0];
    endfunction

    // PC-relative branch: the operand is a two's-complement offset, the sum
    // wraps modulo 2^PCW.
    function automatic logic [PCW-1:0] branch_target(input logic [PCW-1:0] base,
                                                     input logic [OW-1:0]  off);
        logic signed [PCW+OW-1:0] off_wide;
        off_wide = {{PCW{off[OW-1]}}, off};
        return base + off_wide[PCW-1:0];
    endfunction

    acc_rf #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (RIW)
    ) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .waddr (idx),
        .wdata (acc),
        .raddr (idx),
        .rdata (rf_rdata)
    );

    assign rf_we = (state == EXEC) && (opcode == kSTR);

    // Inline ALU: next accumulator value for the instruction held in IR.
    always_comb begin
        alu_op   = decode_alu(opcode);
        acc_next = acc;
        acc_wr   = 1'b1;
        case (alu_op)
            ALU_LDR: acc_next = rf_rdata;
            ALU_LDI: acc_next = imm_data(operand);
            ALU_ADD: acc_next = acc + rf_rdata;
            ALU_SUB: acc_next = acc - rf_rdata;
            ALU_AND: acc_next = acc & rf_rdata;
            ALU_XOR: acc_next = acc ^ rf_rdata;
            ALU_SHL: acc_next = acc << 1;
            default: acc_wr   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            acc        <= '0;
            ir         <= '0;
            z          <= 1'b0;
            neg        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    ir    <= imem_data;
                    state <= EXEC;
                end

                EXEC: begin
                    pc    <= pc + PCW'(1);
                    state <= FETCH;
                    if (acc_wr) begin
                        acc <= acc_next;
                        z   <= (acc_next == '0);
                        neg <= acc_next[DW-1];
                    end
                    case (opcode)
                        kBRZ: if (z)   pc <= branch_target(pc, operand);
                        kBRN: if (neg) pc <= branch_target(pc, operand);
                        kJMP: begin
                            if (operand != '0) begin
                                pc <= jump_target(operand);
                            end else begin
                                // PC stays on the JMP 0 so a halted core
                                // shows where it stopped.
                                pc    <= pc;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= HALT;
                            end
                        end
                        kLDM, kSTM: begin
                            // Request fields are captured here and held
                            // unchanged for the whole MEM wait.
                            pc         <= pc;
                            dmem_req   <= 1'b1;
                            dmem_we    <= (opcode == kSTM);
                            dmem_addr  <= rf_rdata;
                            dmem_wdata <= acc;
                            state      <= MEM;
                        end
                        default: ;
                    endcase
                end

                MEM: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            acc <= dmem_rdata;
                            z   <= (dmem_rdata == '0);
                            neg <= dmem_rdata[DW-1];
                        end
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc       <= pc + PCW'(1);
                        state    <= FETCH;
                    end
                end

                HALT: begin
                    // Restart keeps the register file; everything else that
                    // a program observes starts from zero.
                    if (start) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        pc    <= '0;
                        acc   <= '0;
                        z     <= 1'b0;
                        neg   <= 1'b0;
                        state <= FETCH;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_core_mc.sv
module tb_acc_core_mc;
    import acc_core_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic       busy;
    logic [7:0] imem_addr;
    logic [8:0] imem_data;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic [7:0] dmem_rdata;
    logic       dmem_ack;

    int total = 0;
    int bad   = 0;

    logic [8:0] imem [256];
    logic [8:0] prom [128];
    int         np;
    bit [7:0]   dmem_model [256];
    int         ack_delay = 0;
    int         wait_cnt  = 0;
    logic       stray_ack = 1'b0;

    acc_core_mc #(.DW(8), .IW(9), .NREG(16), .PCW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem_model[dmem_addr];
    assign dmem_ack   = (dmem_req && (wait_cnt >= ack_delay)) || stray_ack;

    // Memory responder: ack after ack_delay waiting cycles, stores land on ack.
    always @(posedge clk) begin
        if (dmem_req && !dmem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (dmem_req && dmem_ack && dmem_we) dmem_model[dmem_addr] <= dmem_wdata;
    end

    typedef struct {
        int         base;
        int         len;
        int         dly;
        logic [7:0] acc;
        logic       z;
        logic       n;
        int         ridx;
        logic [7:0] rval;
        int         cycles;
        logic [7:0] pc;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic emit(input logic [3:0] op, input logic [4:0] od);
        prom[np] = {op, od};
        np++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        stray_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_prog(input int base, input int len);
        for (int a = 0; a < 256; a++) imem[a] = {kJMP, 5'd0};
        for (int k = 0; k < len; k++) imem[k] = prom[base + k];
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles are counted from the edge that sampled start.
    task automatic run_to_done(input string nm, output int cyc);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_done_reached"}, int'(done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int b;
        int req_cycles;
        int stab_err;
        int guard;

        // ---------------- program ROM and vector table ----------------
        np = 0;
        b = np; emit(kLDI,5); emit(kSTR,1); emit(kLDI,3); emit(kADD,1); emit(kSTR,2); emit(kJMP,0);
        vecs[0]  = '{b, np-b, 0, 8'd8,   1'b0, 1'b0, 2, 8'd8,  12, 8'd5};
        b = np; emit(kLDI,31); emit(kSHL,0); emit(kSHL,0); emit(kSHL,0); emit(kSUB,0); emit(kJMP,0);
        vecs[1]  = '{b, np-b, 0, 8'hF8,  1'b0, 1'b1, 0, 8'd0,  12, 8'd5};
        b = np; emit(kLDI,3); emit(kSTR,4); emit(kLDI,12); emit(kXOR,4); emit(kSTR,5); emit(kAND,4); emit(kJMP,0);
        vecs[2]  = '{b, np-b, 0, 8'd3,   1'b0, 1'b0, 5, 8'd15, 14, 8'd6};
        b = np; emit(kLDI,7); emit(kSTR,1); emit(kSUB,1); emit(kJMP,0);
        vecs[3]  = '{b, np-b, 0, 8'd0,   1'b1, 1'b0, 1, 8'd7,  8,  8'd3};
        b = np; emit(kLDI,1); emit(kSTR,1); emit(kLDI,0); emit(kSUB,1); emit(kADD,1); emit(kJMP,0);
        vecs[4]  = '{b, np-b, 0, 8'd0,   1'b1, 1'b0, 1, 8'd1,  12, 8'd5};
        b = np; emit(kLDI,0); emit(kBRZ,2); emit(kLDI,9); emit(kJMP,0);
        vecs[5]  = '{b, np-b, 0, 8'd0,   1'b1, 1'b0, 0, 8'd0,  6,  8'd3};
        b = np; emit(kLDI,1); emit(kBRZ,2); emit(kLDI,9); emit(kJMP,0);
        vecs[6]  = '{b, np-b, 0, 8'd9,   1'b0, 1'b0, 0, 8'd0,  8,  8'd3};
        b = np; emit(kLDI,3); emit(kSTR,2); emit(kLDI,1); emit(kSTR,1); emit(kLDR,2);
                emit(kSUB,1); emit(kSTR,2); emit(kBRZ,2); emit(kJMP,4); emit(kJMP,0);
        vecs[7]  = '{b, np-b, 0, 8'd0,   1'b1, 1'b0, 2, 8'd0,  38, 8'd9};
        b = np; emit(kLDI,1); emit(kSTR,1); emit(kLDI,0); emit(kSUB,1); emit(kBRN,2); emit(kLDI,9); emit(kJMP,0);
        vecs[8]  = '{b, np-b, 0, 8'hFF,  1'b0, 1'b1, 1, 8'd1,  12, 8'd6};
        b = np; emit(kLDI,6); emit(4'd15,0); emit(kJMP,0);
        vecs[9]  = '{b, np-b, 0, 8'd6,   1'b0, 1'b0, 0, 8'd0,  6,  8'd2};
        b = np; emit(kLDI,0); emit(4'd14,0); emit(kBRZ,5'h1D);
        vecs[10] = '{b, np-b, 0, 8'd0,   1'b1, 1'b0, 0, 8'd0,  8,  8'hFF};
        b = np; emit(kLDI,17); emit(kSTR,7); emit(kLDI,0); emit(kLDR,7); emit(kJMP,0);
        vecs[11] = '{b, np-b, 0, 8'd17,  1'b0, 1'b0, 7, 8'd17, 10, 8'd4};
        b = np; emit(kLDI,21); emit(kSTR,3); emit(kLDI,10); emit(kSTM,3); emit(kLDI,0); emit(kLDM,3); emit(kJMP,0);
        vecs[12] = '{b, np-b, 0, 8'd10,  1'b0, 1'b0, 3, 8'd21, 16, 8'd6};
        b = np; emit(kLDI,22); emit(kSTR,3); emit(kLDI,30); emit(kSTM,3); emit(kLDI,0); emit(kLDM,3); emit(kJMP,0);
        vecs[13] = '{b, np-b, 2, 8'd30,  1'b0, 1'b0, 3, 8'd22, 20, 8'd6};
        b = np; emit(kLDI,0); emit(kSTR,6); emit(kBRN,2); emit(kJMP,0);
        vecs[14] = '{b, np-b, 0, 8'd0,   1'b1, 1'b0, 6, 8'd0,  8,  8'd3};

        // ---------------- reset state ----------------
        load_prog(vecs[0].base, vecs[0].len);
        do_reset();
        #1;
        chk("rst_done",  int'(done), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_req",   int'(dmem_req), 0);
        chk("rst_we",    int'(dmem_we), 0);
        chk("rst_pc",    int'(imem_addr), 0);
        chk("rst_acc",   int'(dut.acc), 0);
        chk("rst_state", int'(dut.state), int'(IDLE));

        // ---------------- table-driven programs ----------------
        for (int v = 0; v < NV; v++) begin
            do_reset();
            load_prog(vecs[v].base, vecs[v].len);
            ack_delay = vecs[v].dly;
            pulse_start();
            run_to_done($sformatf("v%0d", v), cyc);
            chk($sformatf("v%0d_cycles", v), cyc, vecs[v].cycles);
            chk($sformatf("v%0d_acc", v), int'(dut.acc), int'(vecs[v].acc));
            chk($sformatf("v%0d_z", v), int'(dut.z), int'(vecs[v].z));
            chk($sformatf("v%0d_neg", v), int'(dut.neg), int'(vecs[v].n));
            chk($sformatf("v%0d_reg", v), int'(dut.u_rf.regs[vecs[v].ridx]), int'(vecs[v].rval));
            chk($sformatf("v%0d_pc", v), int'(imem_addr), int'(vecs[v].pc));
        end

        // ---------------- memory handshake with delayed ack ----------------
        np = 64;
        b = np; emit(kLDI,2); emit(kSTR,4); emit(kLDI,16); emit(kSTR,3); emit(kLDI,21);
                emit(kSHL,0); emit(kSHL,0); emit(kSHL,0); emit(kADD,4); emit(kSTM,3);
                emit(kLDM,5); emit(kJMP,0);
        do_reset();
        load_prog(b, np - b);
        ack_delay = 4;
        stray_ack = 1'b1;   // acks outside MEM must be ignored
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        stray_ack = 1'b0;
        guard = 0;
        while (!dmem_req && guard < 60) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("stm_req_seen", int'(dmem_req), 1);
        chk("stm_addr", int'(dmem_addr), 8'h10);
        chk("stm_wdata", int'(dmem_wdata), 8'hAA);
        chk("stm_we", int'(dmem_we), 1);
        req_cycles = 0;
        stab_err = 0;
        while (dmem_req && req_cycles < 20) begin
            if (dmem_addr !== 8'h10 || dmem_wdata !== 8'hAA || dmem_we !== 1'b1) stab_err++;
            req_cycles++;
            @(posedge clk);
            #1;
        end
        chk("stm_req_cycles", req_cycles, 5);
        chk("stm_stable", stab_err, 0);
        chk("stm_pc_after", int'(imem_addr), 10);
        run_to_done("ldm", cyc);
        chk("stm_stored", int'(dmem_model[8'h10]), 8'hAA);
        chk("ldm_acc", int'(dut.acc), 0);
        chk("ldm_z", int'(dut.z), 1);
        chk("ldm_neg", int'(dut.neg), 0);

        // ---------------- reset during MEM ----------------
        b = np; emit(kLDI,1); emit(kSTM,0); emit(kJMP,0);
        do_reset();
        load_prog(b, np - b);
        ack_delay = 50;
        pulse_start();
        guard = 0;
        while (!dmem_req && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("rmem_req_seen", int'(dmem_req), 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rmem_req", int'(dmem_req), 0);
        chk("rmem_busy", int'(busy), 0);
        chk("rmem_pc", int'(imem_addr), 0);
        chk("rmem_state", int'(dut.state), int'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 0;

        // ---------------- restart keeps registers, start while busy ignored ----------------
        do_reset();
        load_prog(vecs[0].base, vecs[0].len);
        pulse_start();
        run_to_done("rs_first", cyc);
        chk("rs_first_r2", int'(dut.u_rf.regs[2]), 8);
        b = np; emit(kLDR,2); emit(kADD,2); emit(kJMP,0);
        load_prog(b, np - b);
        pulse_start();
        chk("rs_done_fall", int'(done), 0);
        chk("rs_busy", int'(busy), 1);
        chk("rs_acc_clr", int'(dut.acc), 0);
        chk("rs_reg_kept", int'(dut.u_rf.regs[2]), 8);
        cyc = 0;
        while (!done && cyc < 100) begin
            start = (cyc == 2);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk("rs_second_done", int'(done), 1);
        chk("rs_second_cycles", cyc, 6);
        chk("rs_second_acc", int'(dut.acc), 16);
        chk("rs_second_pc", int'(imem_addr), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
